reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
Out-of-order-completion counterpart to the team's in-order 16x4 FIFO.
- Producers allocate slots in program order and receive a tag.
- Completions write results back by tag in any order.
- Results are released to the consumer strictly in allocation order through a valid/ready retire port.
- Sits between an issue stage (allocator) and an in-order commit stage.

Parameters:
DATA_W, 4, width of result payload
DEPTH, 16, number of entries; power of two, >= 2
ID_W, $clog2(DEPTH), tag width; derived, not overridden

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  synchronous, active-high reset
alloc_req_i  input  1  request a new slot this cycle
alloc_gnt_o  output  1  slot granted; equals !full_o
alloc_id_o  output  ID_W  tag of the slot granted this cycle (tail index)
wb_valid_i  input  1  writeback strobe
wb_id_i  input  ID_W  tag being completed
wb_data_i  input  DATA_W  result for that tag
wb_err_o  output  1  registered one-cycle pulse: previous writeback was illegal
ret_valid_o  output  1  head entry allocated and complete
ret_id_o  output  ID_W  tag of head entry
ret_data_o  output  DATA_W  result of head entry
ret_ready_i  input  1  consumer accepts head
full_o  output  1  all DEPTH slots allocated
empty_o  output  1  no slots allocated
count_o  output  ID_W+1  number of allocated slots, 0..DEPTH

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Pointers:
  - head and tail are ID_W+1 bits, with the MSB as wrap bit.
  - empty = (tail == head).
  - full = (tail == {~head[ID_W], head[ID_W-1:0]}).
  - count = tail - head, modulo 2^(ID_W+1).
- Per-entry state: alloc bit, done bit, DATA_W data. The data array is not reset.
- Reset, rst_i sampled high at an edge:
  - head = tail = 0; all alloc/done bits cleared; wb_err_o = 0.
  - Resulting outputs: alloc_gnt_o = 1, alloc_id_o = 0, empty_o = 1, full_o = 0, count_o = 0, ret_valid_o = 0.
  - While rst_i is high, all alloc/wb/retire inputs are ignored.
  - Reset mid-operation discards all entries.
- Allocate:
  - Fires when alloc_req_i && !full.
  - alloc_id_o = tail[ID_W-1:0], combinational from registered tail.
  - Next edge: alloc[tail] = 1, done[tail] = 0, tail += 1.
  - When full, the request is ignored; no grant.
- Writeback:
  - Legal iff alloc[wb_id_i] && !done[wb_id_i] (state before the edge).
  - Legal: next edge sets done = 1 and stores wb_data_i.
  - Illegal (unallocated slot, or already done): no state change, and wb_err_o = 1 for exactly the next cycle.
- Retire:
  - ret_valid_o = !empty && done[head]; ret_id_o and ret_data_o come from head, combinational from registers.
  - Fires when ret_valid_o && ret_ready_i.
  - Next edge: alloc[head] = 0, done[head] = 0, head += 1.
  - ret_data_o must stay stable while ret_valid_o is high and not accepted.
- Latency:
  - Writeback to head -> ret_valid_o high in the next cycle; no same-cycle bypass.
  - Allocate -> earliest legal writeback is the next cycle.
- Simultaneous events:
  - Allocate, writeback and retire may all fire in the same cycle, each evaluated on pre-edge state.
  - Full plus retire in the same cycle: no grant that cycle (no freed-slot bypass). Grant is available next cycle.
  - Empty plus allocate: no retire; ret_valid_o needs done, which needs a later writeback.
  - Writeback to the head tag in the same cycle head retires: illegal (already done) -> err pulse; the retire still completes.
- Wrap-around: the tail index wraps 15 -> 0; the wrap bit distinguishes full from empty. Tags are reused only after the slot has retired.
- count_o ranges 0..DEPTH inclusive (ID_W+1 bits).

Decomposition:
- Package rob_pkg holds:
  - localparams DATA_W, DEPTH, ID_W.
  - typedefs rob_id_t [ID_W-1:0], rob_ptr_t [ID_W:0], rob_data_t [DATA_W-1:0].
  - struct rob_entry_t {alloc, done, data}.
- One sub-module, rob_ptr_ctrl, is natural: it holds head/tail registers, full/empty/count, and takes inc_head/inc_tail strobes. It is reusable by the FIFO family.
- The entry array and writeback legality check stay in reorder_buffer.

Test Plan:
1. Reset, then alloc x3 -> ids 0,1,2, count_o=3. Writeback order id2=0xA, id0=0xC, id1=0xB with ret_ready_i=1 -> retire in order (0,0xC),(1,0xB),(2,0xA); retire of id0 occurs the cycle after its writeback.
2. Alloc 16 back-to-back -> full_o=1, count_o=16, 17th request gets no grant. Complete and retire id0 -> full_o drops the cycle after retire. Next alloc returns id0 (wrap).
3. Backpressure: head done with data 0x5, ret_ready_i=0 for 4 cycles -> ret_valid_o=1 with ret_data_o=0x5 stable, head unchanged. ready=1 -> one retire.
4. Illegal writebacks: wb to unallocated id7 -> wb_err_o pulses 1 cycle, no state change. Double wb to id0 -> second one pulses err, data keeps the first value.
5. Same-cycle alloc + writeback + retire with count=5 -> count_o stays 5, tail and head each advance by 1.
6. Reset asserted with 10 entries in flight, some done -> next cycle empty_o=1, ret_valid_o=0, count_o=0, alloc_id_o=0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared sizes and types for the reorder buffer and its pointer controller.
package rob_pkg;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
  localparam int ID_W   = $clog2(DEPTH);

  typedef logic [ID_W-1:0]   rob_id_t;
  typedef logic [ID_W:0]     rob_ptr_t;
  typedef logic [DATA_W-1:0] rob_data_t;

  typedef struct packed {
    logic      alloc;
    logic      done;
    rob_data_t data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointer pair with wrap bit; derives full, empty and occupancy.
module rob_ptr_ctrl #(
  parameter  int DEPTH = 16,
  localparam int ID_W  = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_head_i,
  input  logic            inc_tail_i,
  output logic [ID_W-1:0] head_idx_o,
  output logic [ID_W-1:0] tail_idx_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [ID_W:0]   count_o
);

  localparam logic [ID_W:0] PTR_ONE = (ID_W+1)'(1);

  logic [ID_W:0] head_q, head_d;
  logic [ID_W:0] tail_q, tail_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (inc_head_i) head_d = head_q + PTR_ONE;
    if (inc_tail_i) tail_d = tail_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Equal indices with differing wrap bits means the tail lapped the head.
  assign empty_o    = (tail_q == head_q);
  assign full_o     = (tail_q == {~head_q[ID_W], head_q[ID_W-1:0]});
  assign count_o    = tail_q - head_q;
  assign head_idx_o = head_q[ID_W-1:0];
  assign tail_idx_o = tail_q[ID_W-1:0];

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation, out-of-order writeback by tag,
// in-order release through a valid/ready retire port.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_req_i,
  output logic              alloc_gnt_o,
  output logic [ID_W-1:0]   alloc_id_o,
  input  logic              wb_valid_i,
  input  logic [ID_W-1:0]   wb_id_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_err_o,
  output logic              ret_valid_o,
  output logic [ID_W-1:0]   ret_id_o,
  output logic [DATA_W-1:0] ret_data_o,
  input  logic              ret_ready_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ID_W:0]     count_o
);

  logic [DEPTH-1:0] alloc_q, alloc_d;
  logic [DEPTH-1:0] done_q, done_d;
  rob_data_t        data_q [DEPTH];

  rob_id_t    head_idx;
  rob_id_t    tail_idx;
  rob_entry_t head_entry;

  logic alloc_fire;
  logic ret_fire;
  logic wb_legal;
  logic wb_err_q, wb_err_d;

  rob_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_head_i (ret_fire),
    .inc_tail_i (alloc_fire),
    .head_idx_o (head_idx),
    .tail_idx_o (tail_idx),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o)
  );

  // All decisions below look only at pre-edge state, so the three events
  // can fire together without interfering.
  assign alloc_fire = alloc_req_i && !full_o;
  assign wb_legal   = wb_valid_i && alloc_q[wb_id_i] && !done_q[wb_id_i];
  assign wb_err_d   = wb_valid_i && !wb_legal;

  assign head_entry = '{alloc: alloc_q[head_idx],
                        done:  done_q[head_idx],
                        data:  data_q[head_idx]};

  assign ret_valid_o = !empty_o && head_entry.alloc && head_entry.done;
  assign ret_fire    = ret_valid_o && ret_ready_i;
  assign ret_id_o    = head_idx;
  assign ret_data_o  = head_entry.data;

  assign alloc_gnt_o = !full_o;
  assign alloc_id_o  = tail_idx;
  assign wb_err_o    = wb_err_q;

  // Per-slot next state. Allocate and retire never hit the same slot in one
  // cycle (that needs full and empty at once), and a legal writeback can
  // never target the retiring head since the head is already done.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic alloc_hit;
    logic ret_hit;
    logic wb_hit;

    assign alloc_hit = alloc_fire && (tail_idx == rob_id_t'(gi));
    assign ret_hit   = ret_fire   && (head_idx == rob_id_t'(gi));
    assign wb_hit    = wb_legal   && (wb_id_i  == rob_id_t'(gi));

    assign alloc_d[gi] = alloc_hit ? 1'b1 :
                         ret_hit   ? 1'b0 : alloc_q[gi];
    assign done_d[gi]  = (alloc_hit || ret_hit) ? 1'b0 :
                         wb_hit                 ? 1'b1 : done_q[gi];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q  <= '0;
      done_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      alloc_q  <= alloc_d;
      done_q   <= done_d;
      wb_err_q <= wb_err_d;
    end
  end

  // Payload storage carries no reset; the done bit qualifies it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wb_legal) begin
      data_q[wb_id_i] <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed-vector bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       alloc_req_i;
  logic       alloc_gnt_o;
  logic [3:0] alloc_id_o;
  logic       wb_valid_i;
  logic [3:0] wb_id_i;
  logic [3:0] wb_data_i;
  logic       wb_err_o;
  logic       ret_valid_o;
  logic [3:0] ret_id_o;
  logic [3:0] ret_data_o;
  logic       ret_ready_i;
  logic       full_o;
  logic       empty_o;
  logic [4:0] count_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  reorder_buffer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alloc_req_i (alloc_req_i),
    .alloc_gnt_o (alloc_gnt_o),
    .alloc_id_o  (alloc_id_o),
    .wb_valid_i  (wb_valid_i),
    .wb_id_i     (wb_id_i),
    .wb_data_i   (wb_data_i),
    .wb_err_o    (wb_err_o),
    .ret_valid_o (ret_valid_o),
    .ret_id_o    (ret_id_o),
    .ret_data_o  (ret_data_o),
    .ret_ready_i (ret_ready_i),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    alloc_req_i = 1'b0;
    wb_valid_i  = 1'b0;
    wb_id_i     = '0;
    wb_data_i   = '0;
    ret_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wb(input logic [3:0] id, input logic [3:0] data);
    wb_valid_i = 1'b1;
    wb_id_i    = id;
    wb_data_i  = data;
    tick();
    wb_valid_i = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    alloc_req_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    alloc_req_i = 1'b0;
  endtask

  initial begin
    do_reset();
    tick();
    chk("rst_gnt",   32'(alloc_gnt_o), 32'd1);
    chk("rst_id",    32'(alloc_id_o),  32'd0);
    chk("rst_empty", 32'(empty_o),     32'd1);
    chk("rst_full",  32'(full_o),      32'd0);
    chk("rst_count", 32'(count_o),     32'd0);
    chk("rst_rv",    32'(ret_valid_o), 32'd0);
    chk("rst_err",   32'(wb_err_o),    32'd0);

    // Out-of-order completion, in-order retire
    alloc_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_gnt", 32'(alloc_gnt_o), 32'd1);
      chk("t1_id",  32'(alloc_id_o),  32'(i));
      tick();
    end
    alloc_req_i = 1'b0;
    chk("t1_count3", 32'(count_o), 32'd3);
    wb(4'd2, 4'hA);
    chk("t1_rv_after_id2", 32'(ret_valid_o), 32'd0);
    ret_ready_i = 1'b1;
    wb(4'd0, 4'hC);
    chk("t1_rv0",   32'(ret_valid_o), 32'd1);
    chk("t1_rid0",  32'(ret_id_o),    32'd0);
    chk("t1_rdat0", 32'(ret_data_o),  32'hC);
    wb(4'd1, 4'hB);
    chk("t1_rv1",   32'(ret_valid_o), 32'd1);
    chk("t1_rid1",  32'(ret_id_o),    32'd1);
    chk("t1_rdat1", 32'(ret_data_o),  32'hB);
    tick();
    chk("t1_rid2",  32'(ret_id_o),    32'd2);
    chk("t1_rdat2", 32'(ret_data_o),  32'hA);
    tick();
    ret_ready_i = 1'b0;
    chk("t1_empty", 32'(empty_o),     32'd1);
    chk("t1_cnt0",  32'(count_o),     32'd0);
    chk("t1_rv_e",  32'(ret_valid_o), 32'd0);

    // Fill to full, retire one, wrap allocate
    do_reset();
    alloc_req_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_id", 32'(alloc_id_o), 32'(i));
      tick();
    end
    alloc_req_i = 1'b0;
    chk("t2_full",  32'(full_o),      32'd1);
    chk("t2_cnt16", 32'(count_o),     32'd16);
    chk("t2_nogn",  32'(alloc_gnt_o), 32'd0);
    alloc_n(1);
    chk("t2_cnt17req", 32'(count_o), 32'd16);
    wb(4'd0, 4'h3);
    chk("t2_rv0", 32'(ret_valid_o), 32'd1);
    ret_ready_i = 1'b1;
    alloc_req_i = 1'b1;
    chk("t2_nobypass", 32'(alloc_gnt_o), 32'd0);
    tick();
    ret_ready_i = 1'b0;
    chk("t2_full_drop", 32'(full_o),      32'd0);
    chk("t2_cnt15",     32'(count_o),     32'd15);
    chk("t2_gnt",       32'(alloc_gnt_o), 32'd1);
    chk("t2_wrap_id",   32'(alloc_id_o),  32'd0);
    tick();
    alloc_req_i = 1'b0;
    chk("t2_refull", 32'(full_o),  32'd1);
    chk("t2_cnt16b", 32'(count_o), 32'd16);

    // Backpressure on head id1
    wb(4'd1, 4'h5);
    for (int i = 0; i < 4; i++) begin
      chk("t3_rv",   32'(ret_valid_o), 32'd1);
      chk("t3_rid",  32'(ret_id_o),    32'd1);
      chk("t3_rdat", 32'(ret_data_o),  32'h5);
      tick();
    end
    ret_ready_i = 1'b1;
    tick();
    ret_ready_i = 1'b0;
    chk("t3_cnt15", 32'(count_o),     32'd15);
    chk("t3_rid2",  32'(ret_id_o),    32'd2);
    chk("t3_rv2",   32'(ret_valid_o), 32'd0);

    // Illegal writebacks
    do_reset();
    alloc_n(1);
    wb(4'd7, 4'hF);
    chk("t4_err_unalloc", 32'(wb_err_o),    32'd1);
    chk("t4_cnt1",        32'(count_o),     32'd1);
    chk("t4_rv_none",     32'(ret_valid_o), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(wb_err_o), 32'd0);
    wb(4'd0, 4'h9);
    chk("t4_err_legal", 32'(wb_err_o),    32'd0);
    chk("t4_rdat9",     32'(ret_data_o),  32'h9);
    wb(4'd0, 4'h6);
    chk("t4_err_dbl",   32'(wb_err_o),    32'd1);
    chk("t4_rdat_keep", 32'(ret_data_o),  32'h9);
    tick();
    chk("t4_err_clr", 32'(wb_err_o), 32'd0);
    ret_ready_i = 1'b1;
    wb(4'd0, 4'h2);
    ret_ready_i = 1'b0;
    chk("t4_err_headret", 32'(wb_err_o), 32'd1);
    chk("t4_retired",     32'(empty_o),  32'd1);

    // Simultaneous alloc + writeback + retire at count 5
    do_reset();
    alloc_n(5);
    wb(4'd0, 4'h1);
    alloc_req_i = 1'b1;
    ret_ready_i = 1'b1;
    chk("t5_aid5", 32'(alloc_id_o),  32'd5);
    chk("t5_rv",   32'(ret_valid_o), 32'd1);
    wb(4'd1, 4'h2);
    alloc_req_i = 1'b0;
    ret_ready_i = 1'b0;
    chk("t5_cnt5",  32'(count_o),     32'd5);
    chk("t5_aid6",  32'(alloc_id_o),  32'd6);
    chk("t5_rid1",  32'(ret_id_o),    32'd1);
    chk("t5_rv1",   32'(ret_valid_o), 32'd1);
    chk("t5_rdat2", 32'(ret_data_o),  32'h2);
    chk("t5_err",   32'(wb_err_o),    32'd0);

    // Reset with entries in flight
    do_reset();
    alloc_n(10);
    wb(4'd0, 4'h4);
    wb(4'd3, 4'h8);
    chk("t6_cnt10", 32'(count_o), 32'd10);
    rst_i       = 1'b1;
    alloc_req_i = 1'b1;
    tick();
    rst_i       = 1'b0;
    alloc_req_i = 1'b0;
    chk("t6_empty", 32'(empty_o),     32'd1);
    chk("t6_rv",    32'(ret_valid_o), 32'd0);
    chk("t6_cnt0",  32'(count_o),     32'd0);
    chk("t6_aid0",  32'(alloc_id_o),  32'd0);
    chk("t6_full",  32'(full_o),      32'd0);
    wb(4'd0, 4'h1);
    chk("t6_err_cleared_slot", 32'(wb_err_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
